// File: rtl/truth_table_checker.sv
// Observes {a,b,c} -> f of a 3-input circuit, captures f after each vector has been
// stable for SETTLE edges, and scores the resulting truth table against EXPECTED.
module truth_table_checker #(
  parameter logic [7:0] EXPECTED = 8'hE8,
  parameter int         SETTLE   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       f,
  output logic       busy,
  output logic       captured,
  output logic [2:0] index,
  output logic [7:0] observed,
  output logic [7:0] covered,
  output logic [3:0] mismatches,
  output logic       done,
  output logic       pass
);

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [2:0] prev_vec, prev_vec_next;
  logic [3:0] cnt, cnt_next;
  logic [7:0] observed_next, covered_next;
  logic [3:0] mismatches_next;
  logic [2:0] index_next;
  logic       captured_next;
  logic [2:0] vec;

  assign vec = {a, b, c};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev_vec   <= 3'd0;
      cnt        <= 4'd0;
      observed   <= 8'd0;
      covered    <= 8'd0;
      mismatches <= 4'd0;
      index      <= 3'd0;
      captured   <= 1'b0;
    end else begin
      state      <= state_next;
      prev_vec   <= prev_vec_next;
      cnt        <= cnt_next;
      observed   <= observed_next;
      covered    <= covered_next;
      mismatches <= mismatches_next;
      index      <= index_next;
      captured   <= captured_next;
    end
  end

  always_comb begin
    state_next      = state;
    prev_vec_next   = prev_vec;
    cnt_next        = cnt;
    observed_next   = observed;
    covered_next    = covered;
    mismatches_next = mismatches;
    index_next      = index;
    captured_next   = 1'b0;

    if (start) begin
      observed_next   = 8'd0;
      covered_next    = 8'd0;
      mismatches_next = 4'd0;
      cnt_next        = 4'd0;
      state_next      = COLLECT;
    end else if (state == COLLECT) begin
      // A freshly loaded vector counts as its first stable edge, so SETTLE=1 captures at once.
      if (cnt == 4'd0 || vec != prev_vec) begin
        prev_vec_next = vec;
        cnt_next      = 4'd1;
        captured_next = (SETTLE_W == 4'd1);
      end else if (cnt < SETTLE_W) begin
        cnt_next      = cnt + 4'd1;
        captured_next = ((cnt + 4'd1) == SETTLE_W);
      end

      if (captured_next) begin
        index_next = vec;
        if (!covered[vec]) begin
          observed_next[vec] = f;
          covered_next[vec]  = 1'b1;
          if (f != EXPECTED[vec] && mismatches != 4'hF)
            mismatches_next = mismatches + 4'd1;
        end else if (f != observed[vec] && mismatches != 4'hF) begin
          mismatches_next = mismatches + 4'd1;
        end
        if (covered_next == 8'hFF)
          state_next = REPORT;
      end
    end
  end

  assign busy = (state == COLLECT);
  assign done = (state == REPORT);
  assign pass = (state == REPORT) && (mismatches == 4'd0);

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: vector table, hand sequences for dwell/reset/saturation,
// and randomized dwells checked every cycle against a run-length reference model.
module tb_truth_table_checker;

  localparam int         SETTLE = 4;
  localparam logic [7:0] EXP    = 8'hE8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, f = 1'b0;
  logic       busy, captured, done, pass;
  logic [2:0] index;
  logic [7:0] observed, covered;
  logic [3:0] mismatches;

  truth_table_checker #(.EXPECTED(EXP), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c(c), .f(f),
    .busy(busy), .captured(captured), .index(index), .observed(observed),
    .covered(covered), .mismatches(mismatches), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: unbounded run length of the current vector, capture when it hits SETTLE.
  bit         m_active, m_report, m_cap;
  int         m_run;
  logic [2:0] m_last, m_idx;
  logic [7:0] m_obs, m_cov;
  int         m_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    m_active = 0; m_report = 0; m_cap = 0; m_run = 0;
    m_last = 3'd0; m_idx = 3'd0; m_obs = 8'd0; m_cov = 8'd0; m_mis = 0;
  endtask

  task automatic model_step();
    logic [2:0] v;
    v = {a, b, c};
    m_cap = 0;
    if (!rst_n) begin
      model_reset();
    end else if (start) begin
      m_active = 1; m_report = 0; m_obs = 8'd0; m_cov = 8'd0; m_mis = 0; m_run = 0;
    end else if (m_active) begin
      if (m_run > 0 && v == m_last) m_run++;
      else begin m_run = 1; m_last = v; end
      if (m_run == SETTLE) begin
        m_cap = 1;
        m_idx = v;
        if (!m_cov[v]) begin
          m_obs[v] = f;
          m_cov[v] = 1'b1;
          if (f != EXP[v]) m_mis = (m_mis < 15) ? m_mis + 1 : 15;
        end else if (f != m_obs[v]) begin
          m_mis = (m_mis < 15) ? m_mis + 1 : 15;
        end
        if (m_cov == 8'hFF) begin m_active = 0; m_report = 1; end
      end
    end
  endtask

  task automatic step();
    logic [3:0] mm;
    model_step();
    @(posedge clk);
    #1;
    mm = 4'(m_mis);
    check("cycle{cap,idx,obs,cov,mis,busy,done,pass}",
          {5'd0, captured, index, observed, covered, mismatches, busy, done, pass},
          {5'd0, m_cap, m_idx, m_obs, m_cov, mm, m_active, m_report, m_report && (m_mis == 0)});
  endtask

  task automatic drive(input logic [2:0] v, input logic fv);
    {a, b, c} = v;
    f = fv;
  endtask

  task automatic hold(input int n, output int caps);
    caps = 0;
    repeat (n) begin
      step();
      if (captured) caps++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  typedef struct {
    bit         st;
    logic [2:0] vec;
    logic       fv;
    int         hold_n;
    int         caps;
    logic [7:0] obs;
    logic [7:0] cov;
    logic [3:0] mis;
    logic       dn;
    logic       ps;
  } rec_t;

  rec_t tbl[18];
  int   mis_stuck[8] = '{0, 0, 0, 1, 1, 2, 3, 4};

  initial begin
    int         caps;
    logic [7:0] mask;
    logic [2:0] v;
    logic       fv;

    for (int i = 0; i < 8; i++) begin
      mask = 8'((16'h1 << (i + 1)) - 16'h1);
      tbl[i]     = '{i == 0, 3'(i), EXP[i], 6, 1, EXP & mask, mask, 4'd0, i == 7, i == 7};
      tbl[8 + i] = '{i == 0, 3'(i), 1'b0, 6, 1, 8'h00, mask, 4'(mis_stuck[i]), i == 7, 1'b0};
    end
    tbl[16] = '{1'b1, 3'd3, 1'b1, 3, 0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 3'd5, 1'b1, 4, 1, 8'h20, 8'h20, 4'd0, 1'b0, 1'b0};

    model_reset();

    // Reset held with toggling inputs, then released without start.
    for (int i = 0; i < 5; i++) begin
      start = 1'(i & 1);
      drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      step();
    end
    start = 1'b0;
    check("reset_outputs", {busy, captured, index, observed, covered, mismatches, done, pass}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(3'(i), EXP[i]);
      hold(6, caps);
      check("idle_no_capture", caps, 0);
    end

    // Table: correct sweep, stuck-at-0 sweep (started from REPORT), short dwell.
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].st) pulse_start();
      drive(tbl[i].vec, tbl[i].fv);
      hold(tbl[i].hold_n, caps);
      $display("rec %0d vec=%0d f=%0d hold=%0d caps=%0d obs=%h cov=%h mis=%0d done=%0d pass=%0d",
               i, tbl[i].vec, tbl[i].fv, tbl[i].hold_n, caps, observed, covered, mismatches, done, pass);
      check("tbl_caps", caps, tbl[i].caps);
      check("tbl_observed", observed, tbl[i].obs);
      check("tbl_covered", covered, tbl[i].cov);
      check("tbl_mismatches", mismatches, tbl[i].mis);
      check("tbl_done_pass", {done, pass}, {tbl[i].dn, tbl[i].ps});
    end
    check("short_dwell_index", index, 3'd5);

    // Instability on vector 000 until the mismatch count saturates.
    pulse_start();
    drive(3'd0, 1'b0);
    hold(4, caps);
    check("sat_first_capture", caps, 1);
    for (int r = 1; r <= 20; r++) begin
      drive(3'd1, 1'b0);
      hold(4, caps);
      drive(3'd0, 1'b1);
      hold(4, caps);
      if (r == 3) check("sat_mis_after_3", mismatches, 4'd3);
    end
    check("sat_mis_15", mismatches, 4'hF);
    check("sat_obs0", observed[0], 1'b0);
    $display("saturation: mis=%0d obs=%h cov=%h", mismatches, observed, covered);

    // Reset mid-run after four captures.
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      drive(3'(i), EXP[i]);
      hold(6, caps);
    end
    check("pre_reset_cov", covered, 8'h0F);
    rst_n = 1'b0;
    #2;
    check("async_reset_cov_busy", {covered, busy, mismatches, observed}, 0);
    model_reset();
    step();
    rst_n = 1'b1;
    drive(3'd6, 1'b1);
    hold(6, caps);
    check("post_reset_no_capture", caps, 0);
    pulse_start();
    drive(3'd5, 1'b1);
    hold(4, caps);
    check("restart_cov", covered, 8'h20);
    check("restart_busy", busy, 1'b1);
    $display("reset mid-run: restart cov=%h busy=%0d", covered, busy);

    // Randomized dwells, occasional restarts.
    pulse_start();
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 19) == 0) pulse_start();
      v  = 3'($urandom_range(0, 7));
      fv = ($urandom_range(0, 4) == 0) ? ~EXP[v] : EXP[v];
      drive(v, fv);
      hold($urandom_range(1, 7), caps);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Response-side companion to the exhaustive 3-input stimulus benches used for DDCO combinational circuits. It watches the input vector {a,b,c} and output f of a circuit under test, captures f once each vector has been stable for SETTLE clocks, and builds the observed 8-entry truth table. It compares that table against a parameterised expected table and reports coverage, mismatch count and pass/fail once all eight vectors have been seen. It sits beside the circuit under test, on the same clock as whatever sequencer drives the vectors.

## Interface
- EXPECTED, 8'hE8, expected truth table; bit i = required f for {a,b,c}=i (default is 3-input majority)
- SETTLE, 4, consecutive sampled edges a vector must hold before capture; legal 1..15
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin (or restart) a collection run; single-cycle pulse
- a, b, c  input  1 each  vector applied to circuit under test; a is MSB of index
- f  input  1  circuit-under-test output
- busy  output  1  high while in COLLECT
- captured  output  1  one-cycle pulse on each capture
- index  output  3  {a,b,c} of the most recent capture
- observed  output  8  captured f values, bit i for vector i
- covered  output  8  bit i set once vector i has been captured
- mismatches  output  4  error count, saturating at 15
- done  output  1  high in REPORT
- pass  output  1  high in REPORT when mismatches==0

## Operation
- States: IDLE, COLLECT, REPORT. Reset -> IDLE; all outputs 0, internal prev_vec=0, cnt=0.
- start in any state: clear observed, covered, mismatches, cnt; go to COLLECT. start has priority over a capture on the same edge.
- COLLECT, per edge, vec={a,b,c}:
  - if cnt==0 or vec!=prev_vec: prev_vec<=vec, cnt<=1
  - else if cnt<SETTLE: cnt<=cnt+1
  - capture when the new cnt equals SETTLE and old cnt!=SETTLE; exactly one capture per stable dwell, however long.
- Capture of vector i, first time (covered[i]==0): observed[i]<=f, covered[i]<=1; if f!=EXPECTED[i], mismatches+1.
- Capture of vector i, already covered: observed/covered unchanged; if f!=observed[i] (unstable circuit), mismatches+1.
- mismatches saturates at 4'hF; never wraps.
- Capture that makes covered==8'hFF moves to REPORT on that same edge.
- REPORT: done=1, pass=(mismatches==0); no further captures; holds until start or reset.
- f is sampled on the capture edge only; changes on f during the dwell are ignored.

## Timing
- All outputs registered; change only on rising clk, except rst_n low clears everything asynchronously.
- Vector first sampled at edge k and unchanged through edge k+SETTLE-1: capture at edge k+SETTLE-1; captured/index/observed/covered/mismatches update after that edge.
- SETTLE=1: capture on the first edge a new vector is sampled.
- captured high exactly one cycle per capture; back-to-back captures are impossible for SETTLE>1.
- done/pass/busy=0 change the same edge as the final capture.
- busy rises the edge after start is sampled.
- rst_n asserted mid-COLLECT: immediate return to IDLE with all outputs 0; deasserting rst_n does not start a run.
- start in REPORT: done, pass drop and busy rises on the next edge.

## Test plan
- Reset: rst_n=0 with toggling inputs -> all outputs 0; release without start, sweep vectors -> captured never pulses.
- Correct sweep: start, drive 000..111 each held 6 cycles, f=majority -> 8 captured pulses, each 3 edges after the vector change; observed=8'hE8, covered=8'hFF, mismatches=0, done=1, pass=1.
- Stuck-at-0 fault: same sweep, f=0 -> observed=8'h00, mismatches=4, done=1, pass=0.
- Short dwell: vector 011 held 3 cycles, then 101 held 4 -> no capture for 011; exactly one capture for 101 (index=5, covered=8'h20).
- Instability and saturation: vector 000 captured with f=0, then toggle 000/001 repeatedly with f=1 on 000 -> mismatches climbs per repeat capture of 000, saturates at 15, observed[0] stays 0.
- Reset mid-run: after 4 captures pull rst_n low one cycle -> covered=0, busy=0 immediately; issue start during a later COLLECT -> counters clear, run restarts.
